// File: rtl/mod_counter.sv
// Up/down modulo counter with a runtime-selectable terminal value, wrap or
// saturate behaviour at the terminal, a synchronous clamped load, a one-cycle
// terminal-step pulse and a sticky overflow flag.
module mod_counter #(
   parameter int unsigned CNT_WIDTH     = 6,
   parameter int unsigned DEFAULT_LIMIT = 39
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [CNT_WIDTH-1:0] rst_val_i,
   input  logic                 en_i,
   input  logic                 dir_i,
   input  logic                 mode_i,
   input  logic                 limit_sel_i,
   input  logic [CNT_WIDTH-1:0] limit_i,
   input  logic                 load_i,
   input  logic [CNT_WIDTH-1:0] load_val_i,
   input  logic                 ovf_clr_i,
   output logic [CNT_WIDTH-1:0] cnt_o,
   output logic                 cnt_end_o,
   output logic                 wrap_o,
   output logic                 ovf_o
);

   localparam logic [CNT_WIDTH-1:0] DefLimit = CNT_WIDTH'(DEFAULT_LIMIT);
   localparam logic [CNT_WIDTH-1:0] One      = CNT_WIDTH'(1);

   logic [CNT_WIDTH-1:0] limit;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 wrap_q, wrap_d;
   logic                 ovf_q, ovf_d;
   logic                 cnt_end;

   // Effective limit and terminal detect; controls act in the same cycle.
   // Up uses >= so a count above the limit (after reset) is also terminal.
   always_comb begin
      limit   = limit_sel_i ? limit_i : DefLimit;
      cnt_end = dir_i ? (cnt_q == '0) : (cnt_q >= limit);
   end

   // Next-state: load beats enable; clear acts alone, an overflow set wins.
   always_comb begin
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
      ovf_d  = ovf_q;
      if (ovf_clr_i) begin
         ovf_d = 1'b0;
      end
      if (load_i) begin
         cnt_d = (load_val_i > limit) ? limit : load_val_i;
      end else if (en_i) begin
         wrap_d = cnt_end;
         if (cnt_end) begin
            ovf_d = 1'b1;
         end
         if (!dir_i) begin
            if (cnt_end) begin
               cnt_d = mode_i ? limit : '0;
            end else begin
               cnt_d = cnt_q + One;
            end
         end else begin
            if (cnt_end) begin
               cnt_d = mode_i ? '0 : limit;
            end else begin
               cnt_d = cnt_q - One;
            end
         end
      end
   end

   // State registers with synchronous reset; reset value is deliberately unclamped.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= rst_val_i;
         wrap_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         wrap_q <= wrap_d;
         ovf_q  <= ovf_d;
      end
   end

   assign cnt_o     = cnt_q;
   assign cnt_end_o = cnt_end;
   assign wrap_o    = wrap_q;
   assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_mod_counter.sv
// Scoreboard bench for mod_counter: the driver pushes expected responses from
// an arithmetic reference model, and an independent monitor pops and compares.
module tb_mod_counter;

   localparam int W = 6;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [W-1:0] rst_val_i = '0;
   logic         en_i = 1'b0;
   logic         dir_i = 1'b0;
   logic         mode_i = 1'b0;
   logic         limit_sel_i = 1'b0;
   logic [W-1:0] limit_i = '0;
   logic         load_i = 1'b0;
   logic [W-1:0] load_val_i = '0;
   logic         ovf_clr_i = 1'b0;
   logic [W-1:0] cnt_o;
   logic         cnt_end_o;
   logic         wrap_o;
   logic         ovf_o;

   mod_counter #(
      .CNT_WIDTH    (W),
      .DEFAULT_LIMIT(39)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rst_val_i  (rst_val_i),
      .en_i       (en_i),
      .dir_i      (dir_i),
      .mode_i     (mode_i),
      .limit_sel_i(limit_sel_i),
      .limit_i    (limit_i),
      .load_i     (load_i),
      .load_val_i (load_val_i),
      .ovf_clr_i  (ovf_clr_i),
      .cnt_o      (cnt_o),
      .cnt_end_o  (cnt_end_o),
      .wrap_o     (wrap_o),
      .ovf_o      (ovf_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit chk_end;
      int end_v;
      int cnt;
      int wrap;
      int ovf;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Reference model state (plain integers)
   int  m_cnt = 0;
   int  m_ovf = 0;
   bit  m_known = 1'b0;

   task automatic check(input string name, input int act, input int expv);
      n_checks++;
      if (act != expv) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   // Apply one cycle of inputs and push what the counter must show for it.
   task automatic drive(input bit r, input int rv, input bit en, input bit dir, input bit mode,
                        input bit sel, input int lim, input bit ld, input int lv, input bit clr);
      int   lmt;
      bit   at_end;
      exp_t e;
      @(negedge clk);
      rst = r; rst_val_i = W'(rv); en_i = en; dir_i = dir; mode_i = mode;
      limit_sel_i = sel; limit_i = W'(lim); load_i = ld; load_val_i = W'(lv); ovf_clr_i = clr;
      lmt    = sel ? lim : 39;
      at_end = dir ? (m_cnt == 0) : (m_cnt >= lmt);
      e.chk_end = m_known;
      e.end_v   = int'(at_end);
      e.wrap    = 0;
      if (r) begin
         m_cnt   = rv;
         m_ovf   = 0;
         m_known = 1'b1;
      end else if (ld) begin
         m_cnt = (lv < lmt) ? lv : lmt;
         if (clr) m_ovf = 0;
      end else if (en) begin
         if (!at_end) m_cnt = dir ? m_cnt - 1 : m_cnt + 1;
         else if (dir) m_cnt = mode ? 0 : lmt;
         else m_cnt = mode ? lmt : 0;
         e.wrap = int'(at_end);
         m_ovf  = at_end ? 1 : (clr ? 0 : m_ovf);
      end else if (clr) begin
         m_ovf = 0;
      end
      e.cnt = m_cnt;
      e.ovf = m_ovf;
      if (!m_known) begin
         e.cnt = int'(cnt_o);
         e.ovf = int'(ovf_o);
      end
      exp_q.push_back(e);
   endtask

   task automatic do_rst(input int rv, input bit sel, input int lim);
      drive(1'b1, rv, 1'b0, 1'b0, 1'b0, sel, lim, 1'b0, 0, 1'b0);
   endtask

   task automatic step(input bit dir, input bit mode, input bit sel, input int lim);
      drive(1'b0, 0, 1'b1, dir, mode, sel, lim, 1'b0, 0, 1'b0);
   endtask

   // Monitor: terminal flag sampled mid-cycle, registered outputs after the edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q[0];
            if (e.chk_end) check("cnt_end_o", int'(cnt_end_o), e.end_v);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            if (e.chk_end || m_known) begin
               check("cnt_o", int'(cnt_o), e.cnt);
               check("wrap_o", int'(wrap_o), e.wrap);
               check("ovf_o", int'(ovf_o), e.ovf);
            end
         end
      end
   end

   initial begin
      // 40 up steps with the default limit: 1..39 then wrap to 0
      do_rst(0, 1'b0, 0);
      for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b0, 0);
      // Down wrap with limit 5
      do_rst(0, 1'b1, 5);
      step(1'b1, 1'b0, 1'b1, 5);
      step(1'b1, 1'b0, 1'b1, 5);
      // Saturate up at 10 from 8, then down saturate at 0
      do_rst(8, 1'b1, 10);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 10);
      drive(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 10, 1'b1, 0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 10);
      step(1'b1, 1'b1, 1'b1, 10);
      // Load beats enable and clamps to the limit
      drive(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 50, 1'b0);
      // Overflow set beats clear, then clear alone
      step(1'b0, 1'b0, 1'b0, 0);
      drive(1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 1'b1);
      drive(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1);
      // Reset mid-count, then shrink the limit below the count
      do_rst(0, 1'b0, 0);
      for (int i = 0; i < 17; i++) step(1'b0, 1'b0, 1'b0, 0);
      do_rst(3, 1'b0, 0);
      step(1'b0, 1'b0, 1'b1, 2);
      // Limit zero: stuck at 0, every step pulses wrap
      for (int i = 0; i < 3; i++) step(1'b0, i[0], 1'b1, 0);
      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         int lim;
         lim = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 63));
         drive($urandom_range(0, 49) == 0, int'($urandom_range(0, 63)),
               $urandom_range(0, 9) < 7, 1'($urandom), 1'($urandom), 1'($urandom), lim,
               $urandom_range(0, 19) == 0, int'($urandom_range(0, 63)),
               $urandom_range(0, 9) == 0);
      end
      @(negedge clk);
      en_i = 1'b0; load_i = 1'b0; ovf_clr_i = 1'b0;
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      #2;
      check("scoreboard_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
